// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Used by seq_detector_param and seq_det_match_cnt.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        ARMED = 2'b10
    } state_t;

    // Wide enough to hold the values 0..len inclusive.
    function automatic int fill_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter with clear and increment.
// A clear that coincides with an increment leaves the count at one.
module seq_det_match_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_W'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with don't-care mask and
// overlap select. Counter built only when SEQ_DETECTOR_MATCH_CNT_EN is defined.
//
// state | meaning
// IDLE  | no configuration loaded, din ignored
// FILL  | collecting the first LEN bits after a load or non-overlapping match
// ARMED | history holds LEN valid bits, compare on every din_valid
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [LEN-1:0]   cfg_pattern,
    input  logic [LEN-1:0]   cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic             armed,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FW = fill_width(LEN);

    state_t          state;
    logic [LEN-1:0]  hist;
    logic [LEN-1:0]  pat;
    logic [LEN-1:0]  msk;
    logic            ovl;
    logic [FW-1:0]   fill;

    logic [LEN-1:0]  shifted;
    logic            last_fill;
    logic            cmp_en;
    logic            hit;

    // The bit completing the fill is compared too, so the earliest match is bit LEN.
    always_comb begin
        shifted   = {hist[LEN-2:0], din};
        last_fill = (state == FILL) && (fill == FW'(LEN - 1));
        cmp_en    = (state == ARMED) || last_fill;
        hit       = cmp_en && (((shifted ^ pat) & msk) == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            hist  <= '0;
            fill  <= '0;
            pat   <= '0;
            msk   <= '0;
            ovl   <= 1'b0;
            match <= 1'b0;
            armed <= 1'b0;
        end else if (cfg_load) begin
            pat   <= cfg_pattern;
            msk   <= cfg_mask;
            ovl   <= cfg_overlap;
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
            match <= 1'b0;
            armed <= 1'b0;
        end else if (din_valid && (state != IDLE)) begin
            match <= hit;
            if (hit && !ovl) begin
                hist  <= '0;
                fill  <= '0;
                state <= FILL;
                armed <= 1'b0;
            end else begin
                hist <= shifted;
                if (state == FILL) begin
                    fill <= fill + FW'(1);
                end
                if (cmp_en) begin
                    state <= ARMED;
                    armed <= 1'b1;
                end
            end
        end else begin
            match <= 1'b0;
        end
    end

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    seq_det_match_cnt #(
        .CNT_W(CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (match),
        .cnt (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed scenarios then random
// traffic, checked against a sliding-window reference model.
module tb_seq_detector_param;

    localparam int LEN     = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             din_valid;
    logic             din;
    logic             cfg_load;
    logic [LEN-1:0]   cfg_pattern;
    logic [LEN-1:0]   cfg_mask;
    logic             cfg_overlap;
    logic             cnt_clr;
    logic             match;
    logic             armed;
    logic [CNT_W-1:0] match_cnt;

    seq_detector_param #(.LEN(LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din        (din),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_mask   (cfg_mask),
        .cfg_overlap(cfg_overlap),
        .cnt_clr    (cnt_clr),
        .match      (match),
        .armed      (armed),
        .match_cnt  (match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             match;
        logic             armed;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: the bits seen since the last load/restart, kept as a window.
    bit             m_loaded;
    bit             win[$];
    logic [LEN-1:0] m_pat, m_msk;
    bit             m_ovl;
    bit             m_match;
    int             m_cnt;

    task automatic model_edge();
        int  next_cnt;
        bit  hit;
        if (!rst) begin
            m_loaded = 0;
            win.delete();
            m_pat = '0; m_msk = '0; m_ovl = 0;
            m_match = 0;
            m_cnt = 0;
        end else begin
            if (!CNT_EN)          next_cnt = 0;
            else if (cnt_clr)     next_cnt = m_match ? 1 : 0;
            else if (m_match)     next_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            else                  next_cnt = m_cnt;
            if (cfg_load) begin
                m_loaded = 1;
                m_pat = cfg_pattern; m_msk = cfg_mask; m_ovl = cfg_overlap;
                win.delete();
                m_match = 0;
            end else if (din_valid && m_loaded) begin
                win.push_back(din);
                if (win.size() > LEN) void'(win.pop_front());
                hit = 0;
                if (win.size() == LEN) begin
                    hit = 1;
                    // win[0] is the oldest bit and lines up with pattern bit LEN-1.
                    for (int i = 0; i < LEN; i++)
                        if (m_msk[LEN-1-i] && (win[i] != m_pat[LEN-1-i])) hit = 0;
                end
                if (hit && !m_ovl) win.delete();
                m_match = hit;
            end else begin
                m_match = 0;
            end
            m_cnt = next_cnt;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_edge();
        e.match = m_match;
        e.armed = m_loaded && (win.size() == LEN);
        e.cnt   = CNT_W'(m_cnt);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic send(input logic d);
        din_valid = 1'b1; din = d;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_gap(input logic d);
        send(d);
        tick();
    endtask

    task automatic load(input logic [LEN-1:0] p, input logic [LEN-1:0] m, input logic o);
        cfg_load = 1'b1; cfg_pattern = p; cfg_mask = m; cfg_overlap = o;
        tick();
        cfg_load = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (match !== e.match) begin
                failures++;
                $display("FAIL match t=%0t got=%b want=%b", $time, match, e.match);
            end
            checks++;
            if (armed !== e.armed) begin
                failures++;
                $display("FAIL armed t=%0t got=%b want=%b", $time, armed, e.armed);
            end
            checks++;
            if (match_cnt !== e.cnt) begin
                failures++;
                $display("FAIL match_cnt t=%0t got=%0d want=%0d", $time, match_cnt, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b0; din_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_mask = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;
        tick(); tick();
        rst = 1'b1;

        // No configuration loaded: din is ignored.
        send_gap(1); send_gap(0); send_gap(1); send_gap(0);

        // Overlapping 1010: matches after bit 4 and bit 6.
        load(4'b1010, 4'b1111, 1'b1);
        send_gap(1); send_gap(0); send_gap(1); send_gap(0);
        send_gap(1); send_gap(0); send_gap(1);
        tick(); tick();

        // Non-overlapping: one match, then refill.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        load(4'b1010, 4'b1111, 1'b0);
        send_gap(1); send_gap(0); send_gap(1); send_gap(0);
        send_gap(1); send_gap(0); send_gap(1);
        tick();

        // Masked compare, then a load that swallows a simultaneous din.
        load(4'b1010, 4'b1011, 1'b1);
        send(1); send(1); send(1); send(0);
        din_valid = 1'b1; din = 1'b1;
        load(4'b1010, 4'b1011, 1'b1);
        din_valid = 1'b0;
        send(1); send(0); send(1);
        tick();

        // Saturation via all-don't-care mask, then clear coinciding with a match.
        load(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) send(i[0]);
        din_valid = 1'b1; din = 1'b0; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0; din_valid = 1'b0;
        tick(); tick();

        // Reset lands with the completing bit: the pending match is dropped.
        load(4'b1010, 4'b1111, 1'b1);
        send(1); send(0); send(1);
        din_valid = 1'b1; din = 1'b0; rst = 1'b0;
        tick();
        din_valid = 1'b0; rst = 1'b1;
        tick(); tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) != 0);
            cfg_load    = ($urandom_range(0, 59) == 0);
            cfg_pattern = LEN'($urandom);
            cfg_mask    = LEN'($urandom) | LEN'($urandom);
            cfg_overlap = $urandom_range(0, 1);
            cnt_clr     = ($urandom_range(0, 23) == 0);
            din_valid   = ($urandom_range(0, 3) != 0);
            din         = $urandom_range(0, 1);
            tick();
        end
        rst = 1'b1; cfg_load = 1'b0; cnt_clr = 1'b0; din_valid = 1'b0;
        tick();

        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
